// File: rtl/cpu_status_wb.sv
// cpu_status_wb: STATUS (flag) write-back for the pipelined MCS8 core.
// The E-stage ALU flags are captured into an M-stage pending entry. One cycle
// later they are merged into the architectural STATUS register. A direct load
// port can overwrite STATUS at any time.
// Optional feature macro: STATUS_BYPASS_EN. When it is defined, STATUS_O also
// shows the pending M-stage flags (and a same-cycle direct load), so decode
// sees the new flags one cycle earlier.
module cpu_status_wb #(
    parameter logic [3:0] RST_STATUS = 4'b0000
) (
    input  logic       CLK_I,
    input  logic       RST_N_I,
    input  logic       E_VALID_I,
    input  logic [7:0] E_OPCODE_I,
    input  logic [3:0] E_ALU_STATUS_I,
    input  logic       STALL_I,
    input  logic       FLUSH_I,
    input  logic       ST_WR_I,
    input  logic [3:0] ST_WDATA_I,
    output logic       M_VALID_O,
    output logic [3:0] M_MASK_O,
    output logic [3:0] M_STATUS_O,
    output logic [3:0] STATUS_O
);

    // Flag bit order {P,S,Z,C}: bit0=C, bit1=Z, bit2=S, bit3=P.
    localparam logic [3:0] MASK_ALL   = 4'b1111;
    localparam logic [3:0] MASK_CARRY = 4'b0001;
    localparam logic [3:0] MASK_NONE  = 4'b0000;

    logic       op_alu;
    logic       op_rot;
    logic [3:0] e_mask;
    logic       e_capture;
    logic [3:0] m_merged;

    logic       m_valid_d,  m_valid_q;
    logic [3:0] m_mask_d,   m_mask_q;
    logic [3:0] m_status_d, m_status_q;
    logic [3:0] status_d,   status_q;

    // Opcode bits [5:3] do not take part in flag classification.
    logic unused_op_bits;
    assign unused_op_bits = ^E_OPCODE_I[5:3];

    // Classify the E-stage opcode and derive the per-flag update mask.
    always_comb begin
        op_alu = ((E_OPCODE_I[7:6] == 2'b10) && (E_OPCODE_I[2:0] != 3'b111)) ||
                 ((E_OPCODE_I[7:6] == 2'b00) && (E_OPCODE_I[2:0] == 3'b100));
        op_rot =  (E_OPCODE_I[7:6] == 2'b00) && (E_OPCODE_I[2:0] == 3'b010);
        if (op_alu) begin
            e_mask = MASK_ALL;
        end else if (op_rot) begin
            e_mask = MASK_CARRY;
        end else begin
            e_mask = MASK_NONE;
        end
        e_capture = E_VALID_I && !FLUSH_I && (e_mask != MASK_NONE);
    end

    // Merge the pending M-stage flags over the architectural STATUS.
    always_comb begin
        m_merged = (status_q & ~m_mask_q) | (m_status_q & m_mask_q);
    end

    // Next-state logic. A stall freezes M and the commit. A killed or
    // non-flag instruction leaves an all-zero, invalid M entry. A direct
    // load overrides any same-cycle commit on every bit.
    always_comb begin
        m_valid_d  = m_valid_q;
        m_mask_d   = m_mask_q;
        m_status_d = m_status_q;
        status_d   = status_q;

        if (!STALL_I) begin
            if (e_capture) begin
                m_valid_d  = 1'b1;
                m_mask_d   = e_mask;
                m_status_d = E_ALU_STATUS_I & e_mask;
            end else begin
                m_valid_d  = 1'b0;
                m_mask_d   = MASK_NONE;
                m_status_d = 4'b0000;
            end
            if (m_valid_q) begin
                status_d = m_merged;
            end
        end

        if (ST_WR_I) begin
            status_d = ST_WDATA_I;
        end
    end

    // State registers. An asynchronous reset discards any pending entry.
    always_ff @(posedge CLK_I or negedge RST_N_I) begin
        if (!RST_N_I) begin
            m_valid_q  <= 1'b0;
            m_mask_q   <= MASK_NONE;
            m_status_q <= 4'b0000;
            status_q   <= RST_STATUS;
        end else begin
            m_valid_q  <= m_valid_d;
            m_mask_q   <= m_mask_d;
            m_status_q <= m_status_d;
            status_q   <= status_d;
        end
    end

    assign M_VALID_O  = m_valid_q;
    assign M_MASK_O   = m_mask_q;
    assign M_STATUS_O = m_status_q;

`ifdef STATUS_BYPASS_EN
    // Forward a same-cycle load, or otherwise the pending M flags, to decode.
    always_comb begin
        if (ST_WR_I) begin
            STATUS_O = ST_WDATA_I;
        end else if (m_valid_q) begin
            STATUS_O = m_merged;
        end else begin
            STATUS_O = status_q;
        end
    end
`else
    // Decode sees only the registered STATUS. Pipeline control holds back
    // conditional branches while an M entry is pending.
    logic unused_bypass;
    assign unused_bypass = 1'b0;
    assign STATUS_O      = status_q;
`endif

endmodule

// File: tb/tb_cpu_status_wb.sv
// Self-checking bench for cpu_status_wb. It runs directed scenarios first,
// then randomized traffic. All traffic is checked against a flag-level
// behavioural model: one optional pending update plus the architectural
// STATUS value.
module tb_cpu_status_wb;

    localparam logic [3:0] RST_ST = 4'b0000;

    logic       CLK_I = 1'b0;
    logic       RST_N_I;
    logic       E_VALID_I;
    logic [7:0] E_OPCODE_I;
    logic [3:0] E_ALU_STATUS_I;
    logic       STALL_I;
    logic       FLUSH_I;
    logic       ST_WR_I;
    logic [3:0] ST_WDATA_I;
    logic       M_VALID_O;
    logic [3:0] M_MASK_O;
    logic [3:0] M_STATUS_O;
    logic [3:0] STATUS_O;

    cpu_status_wb #(.RST_STATUS(RST_ST)) dut (
        .CLK_I          (CLK_I),
        .RST_N_I        (RST_N_I),
        .E_VALID_I      (E_VALID_I),
        .E_OPCODE_I     (E_OPCODE_I),
        .E_ALU_STATUS_I (E_ALU_STATUS_I),
        .STALL_I        (STALL_I),
        .FLUSH_I        (FLUSH_I),
        .ST_WR_I        (ST_WR_I),
        .ST_WDATA_I     (ST_WDATA_I),
        .M_VALID_O      (M_VALID_O),
        .M_MASK_O       (M_MASK_O),
        .M_STATUS_O     (M_STATUS_O),
        .STATUS_O       (STATUS_O)
    );

    always #5 CLK_I = ~CLK_I;

    int n_total = 0;
    int n_pass  = 0;

    // Reference model state.
    logic       pend_v;
    logic [3:0] pend_m;
    logic [3:0] pend_s;
    logic [3:0] arch_st;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Flags an opcode affects: group = op/64 and low = op%8.
    function automatic logic [3:0] flags_of(input logic [7:0] op);
        int grp = int'(op) / 64;
        int lo  = int'(op) % 8;
        if ((grp == 2 && lo != 7) || (grp == 0 && lo == 4)) return 4'd15;
        if (grp == 0 && lo == 2) return 4'd1;
        return 4'd0;
    endfunction

    // Each flag named in the mask takes the pending value. The others keep
    // the base value.
    function automatic logic [3:0] overlay(input logic [3:0] base, input logic [3:0] m,
                                           input logic [3:0] v);
        logic [3:0] r;
        for (int b = 0; b < 4; b++) r[b] = m[b] ? v[b] : base[b];
        return r;
    endfunction

    function automatic logic [3:0] exp_status_o();
`ifdef STATUS_BYPASS_EN
        if (ST_WR_I) return ST_WDATA_I;
        if (pend_v) return overlay(arch_st, pend_m, pend_s);
`endif
        return arch_st;
    endfunction

    task automatic model_reset();
        pend_v = 1'b0; pend_m = 4'd0; pend_s = 4'd0; arch_st = RST_ST;
    endtask

    // Apply one cycle of inputs. Check the outputs at the falling edge, then
    // advance the model across the rising edge.
    task automatic cyc(input logic ev, input logic [7:0] op, input logic [3:0] fl_in,
                       input logic stall, input logic flush, input logic wr,
                       input logic [3:0] wd);
        logic [3:0] nm;
        logic [3:0] nst;
        E_VALID_I = ev; E_OPCODE_I = op; E_ALU_STATUS_I = fl_in;
        STALL_I = stall; FLUSH_I = flush; ST_WR_I = wr; ST_WDATA_I = wd;
        @(negedge CLK_I);
        chk("m_valid",  {7'd0, M_VALID_O}, {7'd0, pend_v});
        chk("m_mask",   {4'd0, M_MASK_O},  {4'd0, pend_m});
        chk("m_status", {4'd0, M_STATUS_O}, {4'd0, pend_s});
        chk("status_o", {4'd0, STATUS_O},  {4'd0, exp_status_o()});
        nst = arch_st;
        if (!stall) begin
            if (pend_v) nst = overlay(arch_st, pend_m, pend_s);
            nm = flags_of(op);
            if (ev && !flush && nm != 0) begin
                pend_v = 1'b1; pend_m = nm; pend_s = fl_in & nm;
            end else begin
                pend_v = 1'b0; pend_m = 4'd0; pend_s = 4'd0;
            end
        end
        if (wr) nst = wd;
        arch_st = nst;
        @(posedge CLK_I);
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0);
    endtask

    initial begin
        logic [7:0] op;
        logic [3:0] early;
        RST_N_I = 1'b0;
        E_VALID_I = 1'b0; E_OPCODE_I = 8'h00; E_ALU_STATUS_I = 4'h0;
        STALL_I = 1'b0; FLUSH_I = 1'b0; ST_WR_I = 1'b0; ST_WDATA_I = 4'h0;
        model_reset();
        repeat (2) @(posedge CLK_I);
        #1;
        chk("rst_status", {4'd0, STATUS_O}, {4'd0, RST_ST});
        chk("rst_mvalid", {7'd0, M_VALID_O}, 8'd0);
        chk("rst_mmask",  {4'd0, M_MASK_O}, 8'd0);
        RST_N_I = 1'b1;
        idle();

        // ALU op: the flags appear in M after one cycle and in STATUS after two.
        cyc(1'b1, 8'h80, 4'b1011, 1'b0, 1'b0, 1'b0, 4'h0);
        chk("alu_mvalid", {7'd0, M_VALID_O}, 8'd1);
        chk("alu_mmask",  {4'd0, M_MASK_O}, 8'h0F);
`ifdef STATUS_BYPASS_EN
        early = 4'b1011;
`else
        early = 4'b0000;
`endif
        chk("alu_early", {4'd0, STATUS_O}, {4'd0, early});
        idle();
        chk("alu_status", {4'd0, STATUS_O}, 8'h0B);

        // ROT op: only the C flag changes.
        cyc(1'b0, 8'h00, 4'h0, 1'b0, 1'b0, 1'b1, 4'b0110);
        cyc(1'b1, 8'h02, 4'b1111, 1'b0, 1'b0, 1'b0, 4'h0);
        chk("rot_mmask", {4'd0, M_MASK_O}, 8'h01);
        idle();
        chk("rot_status", {4'd0, STATUS_O}, 8'h07);

        // A flushed ALU op and a non-flag op both leave STATUS unchanged.
        cyc(1'b1, 8'h80, 4'b0000, 1'b0, 1'b1, 1'b0, 4'h0);
        chk("flush_mvalid", {7'd0, M_VALID_O}, 8'd0);
        cyc(1'b1, 8'h44, 4'b0000, 1'b0, 1'b0, 1'b0, 4'h0);
        chk("nonflag_mvalid", {7'd0, M_VALID_O}, 8'd0);
        idle();
        chk("nochange_status", {4'd0, STATUS_O}, 8'h07);

        // Stall holds a pending entry, which commits one cycle after the stall ends.
        cyc(1'b1, 8'h80, 4'b0101, 1'b0, 1'b0, 1'b0, 4'h0);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 8'h80, 4'b1010, 1'b1, 1'b1, 1'b0, 4'h0);
            chk("stall_mstatus", {4'd0, M_STATUS_O}, 8'h05);
            chk("stall_mmask",   {4'd0, M_MASK_O}, 8'h0F);
        end
        idle();
        chk("post_stall_status", {4'd0, STATUS_O}, 8'h05);

        // A direct load overrides a same-cycle commit on every bit.
        cyc(1'b1, 8'h80, 4'b0111, 1'b0, 1'b0, 1'b0, 4'h0);
        cyc(1'b0, 8'h00, 4'h0, 1'b0, 1'b0, 1'b1, 4'b1000);
        chk("wr_override", {4'd0, STATUS_O}, 8'h08);
        idle();

        // Reset in the middle of a cycle with an entry pending.
        cyc(1'b1, 8'h80, 4'b1111, 1'b0, 1'b0, 1'b0, 4'h0);
        E_VALID_I = 1'b0;
        #3;
        RST_N_I = 1'b0;
        #1;
        chk("async_rst_status", {4'd0, STATUS_O}, {4'd0, RST_ST});
        chk("async_rst_mvalid", {7'd0, M_VALID_O}, 8'd0);
        model_reset();
        @(posedge CLK_I);
        #1;
        RST_N_I = 1'b1;
        idle();
        idle();

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            case ($urandom % 4)
                0: op = {2'b10, 6'($urandom)};
                1: op = {2'b00, 3'($urandom), 3'b100};
                2: op = {2'b00, 3'($urandom), 3'b010};
                default: op = 8'($urandom);
            endcase
            cyc(($urandom % 4) != 0, op, 4'($urandom), ($urandom % 5) == 0,
                ($urandom % 6) == 0, ($urandom % 8) == 0, 4'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
